// File: rtl/bram_port_arbiter.sv
// Round-robin, burst-locking arbiter sharing one block RAM port between NUM_REQ requesters.
// Define ARB_FIXED_PRIO_EN to select the lowest-index requester instead of round-robin.
module bram_port_arbiter #(
    parameter int NUM_REQ   = 3,
    parameter int ADDR_W    = 30,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 16,
    parameter int RD_LAT    = 1
) (
    input  logic                      clk,
    input  logic                      RESET,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        we,
    input  logic [NUM_REQ-1:0]        last,
    input  logic [NUM_REQ*ADDR_W-1:0] addr,
    input  logic [NUM_REQ*DATA_W-1:0] wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]         rdata,
    input  logic [DATA_W-1:0]         BRAMdataIn,
    output logic [DATA_W-1:0]         BRAMDataOut,
    output logic [ADDR_W+1:0]         BRAMaddrByte,
    output logic [3:0]                BRAMWREN,
    output logic                      BRAMENMEM,
    output logic                      busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_BURST);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   owner;
    logic [CNT_W-1:0]   beat_cnt;
    logic [IDX_W-1:0]   winner;
    logic [IDX_W-1:0]   next_ptr;
    logic               any_req;
    logic               beat;
    logic               owner_we;
    logic               owner_last;
    logic               release_now;

    logic [RD_LAT-1:0]  tag_valid;
    logic [IDX_W-1:0]   tag_idx [RD_LAT];

    assign any_req    = |req;
    assign owner_we   = we[owner];
    assign owner_last = last[owner];
    assign beat       = (state == GRANT) && req[owner];
    assign next_ptr   = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

    // A dropped request releases without a beat; last or the burst cap release on the beat itself.
    assign release_now = (state == GRANT) &&
                         (!req[owner] || (beat && (owner_last || beat_cnt == LAST_BEAT)));

`ifdef ARB_FIXED_PRIO_EN
    always_comb begin
        winner = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[k]) begin
                winner = IDX_W'(k);
            end
        end
    end
`else
    logic [IDX_W-1:0] rr_ptr;

    // Scan upward from the pointer with wrap-around; the first active request wins.
    always_comb begin
        int  idx;
        logic found;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = IDX_W'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            rr_ptr <= '0;
        end else if (release_now) begin
            rr_ptr <= next_ptr;
        end
    end
`endif

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            state    <= IDLE;
            owner    <= '0;
            gnt      <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state    <= GRANT;
                        owner    <= winner;
                        gnt      <= NUM_REQ'(1) << winner;
                        beat_cnt <= '0;
                    end
                end
                GRANT: begin
                    if (beat && beat_cnt != CNT_MAX) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                    if (release_now) begin
                        state <= IDLE;
                        gnt   <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                end
            endcase
        end
    end

    // Read tags travel independently of the grant so a new owner can start while reads drain.
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            tag_valid <= '0;
            for (int s = 0; s < RD_LAT; s++) begin
                tag_idx[s] <= '0;
            end
        end else begin
            tag_valid[0] <= beat && !owner_we;
            tag_idx[0]   <= owner;
            for (int s = 1; s < RD_LAT; s++) begin
                tag_valid[s] <= tag_valid[s-1];
                tag_idx[s]   <= tag_idx[s-1];
            end
        end
    end

    always_comb begin
        rvalid = '0;
        if (tag_valid[RD_LAT-1]) begin
            rvalid[tag_idx[RD_LAT-1]] = 1'b1;
        end
    end

    always_comb begin
        BRAMENMEM    = 1'b0;
        BRAMWREN     = 4'b0000;
        BRAMDataOut  = '0;
        BRAMaddrByte = '0;
        if (beat) begin
            BRAMENMEM    = 1'b1;
            BRAMWREN     = owner_we ? 4'b1111 : 4'b0000;
            BRAMDataOut  = wdata[owner*DATA_W +: DATA_W];
            BRAMaddrByte = {addr[owner*ADDR_W +: ADDR_W], 2'b00};
        end
    end

    assign rdata = BRAMdataIn;
    assign busy  = (state == GRANT) || (|tag_valid);

endmodule
